// File: rtl/inst_rom_arb_pkg.sv
// Shared definitions for the instruction ROM arbiter: bus width defaults,
// ROM geometry, chip-enable levels and the response-owner encoding.
package inst_rom_arb_pkg;

  localparam int ADDR_W_DEF       = 32;
  localparam int DATA_W_DEF       = 32;
  localparam int InstMemNumLog2   = 17;
  localparam int DBG_MAX_WAIT_DEF = 8;

  localparam logic [31:0] ZeroWord    = 32'h0000_0000;
  localparam logic        ChipEnable  = 1'b1;
  localparam logic        ChipDisable = 1'b0;

  // Who receives the word registered at the previous edge
  typedef enum logic [1:0] {
    RSP_NONE    = 2'd0,
    RSP_CPU     = 2'd1,
    RSP_DBG     = 2'd2,
    RSP_DBG_ERR = 2'd3
  } rsp_owner_t;

endpackage

// File: rtl/inst_rom_arb_sel.sv
// Combinational grant selection, debug address check and ROM drive for
// the instruction ROM arbiter.
module inst_rom_arb_sel
  import inst_rom_arb_pkg::*;
#(
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int MEM_LOG2     = InstMemNumLog2,
  parameter int DBG_MAX_WAIT = DBG_MAX_WAIT_DEF,
  parameter int CNT_W        = 4
) (
  input  logic              rst,
  input  logic              cpu_req,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic              dbg_req,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [CNT_W-1:0]  wait_cnt,
  output logic              cpu_gnt,
  output logic              dbg_gnt,
  output logic              rom_ce,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              dbg_bad
);

  logic dbg_force;
  logic hi_bad;
  logic lo_bad;

  // Any address bit beyond the ROM word index makes a debug access illegal
  generate
    if (ADDR_W > MEM_LOG2 + 2) begin : g_hi_check
      assign hi_bad = |dbg_addr[ADDR_W-1:MEM_LOG2+2];
    end else begin : g_no_hi_check
      assign hi_bad = 1'b0;
    end
  endgenerate

  assign lo_bad    = |dbg_addr[1:0];
  assign dbg_bad   = lo_bad | hi_bad;
  assign dbg_force = (wait_cnt == CNT_W'(DBG_MAX_WAIT));

  always_comb begin
    cpu_gnt  = 1'b0;
    dbg_gnt  = 1'b0;
    rom_ce   = ChipDisable;
    rom_addr = '0;
    if (rst) begin
      if (dbg_req && (dbg_force || !cpu_req)) begin
        dbg_gnt = 1'b1;
      end else if (cpu_req) begin
        cpu_gnt = 1'b1;
      end
    end
    // Bad debug addresses are granted but never reach the ROM
    if (cpu_gnt) begin
      rom_ce   = ChipEnable;
      rom_addr = cpu_addr;
    end else if (dbg_gnt && !dbg_bad) begin
      rom_ce   = ChipEnable;
      rom_addr = dbg_addr;
    end
  end

endmodule

// File: rtl/inst_rom_arb.sv
// Shares the single-ported instruction ROM between CPU fetch and a debug
// read port, returning the registered word one cycle after the grant.
module inst_rom_arb
  import inst_rom_arb_pkg::*;
#(
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int DATA_W       = DATA_W_DEF,
  parameter int MEM_LOG2     = InstMemNumLog2,
  parameter int DBG_MAX_WAIT = DBG_MAX_WAIT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic [ADDR_W-1:0] cpu_addr,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dbg_req,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              dbg_err,
  output logic              rom_ce,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_inst
);

  localparam int CNT_W = $clog2(DBG_MAX_WAIT + 1);

  logic [CNT_W-1:0] wait_cnt;
  logic             dbg_bad;
  rsp_owner_t       rsp_owner;
  rsp_owner_t       rsp_next;

  inst_rom_arb_sel #(
    .ADDR_W       (ADDR_W),
    .MEM_LOG2     (MEM_LOG2),
    .DBG_MAX_WAIT (DBG_MAX_WAIT),
    .CNT_W        (CNT_W)
  ) u_sel (
    .rst      (rst),
    .cpu_req  (cpu_req),
    .cpu_addr (cpu_addr),
    .dbg_req  (dbg_req),
    .dbg_addr (dbg_addr),
    .wait_cnt (wait_cnt),
    .cpu_gnt  (cpu_gnt),
    .dbg_gnt  (dbg_gnt),
    .rom_ce   (rom_ce),
    .rom_addr (rom_addr),
    .dbg_bad  (dbg_bad)
  );

  // Counts consecutive lost cycles of a pending debug request
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt <= '0;
    end else if (!dbg_req || dbg_gnt) begin
      wait_cnt <= '0;
    end else if (wait_cnt != CNT_W'(DBG_MAX_WAIT)) begin
      wait_cnt <= wait_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rsp_owner <= RSP_NONE;
    end else begin
      rsp_owner <= rsp_next;
    end
  end

  always_comb begin
    rsp_next = RSP_NONE;
    if (cpu_gnt) begin
      rsp_next = RSP_CPU;
    end else if (dbg_gnt) begin
      rsp_next = dbg_bad ? RSP_DBG_ERR : RSP_DBG;
    end
  end

  // Only the granted side captures; the other side's word is held
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cpu_rdata <= '0;
      dbg_rdata <= '0;
    end else begin
      if (cpu_gnt) begin
        cpu_rdata <= rom_inst;
      end
      if (dbg_gnt) begin
        dbg_rdata <= dbg_bad ? DATA_W'(ZeroWord) : rom_inst;
      end
    end
  end

  assign cpu_rvalid = (rsp_owner == RSP_CPU);
  assign dbg_rvalid = (rsp_owner == RSP_DBG) || (rsp_owner == RSP_DBG_ERR);
  assign dbg_err    = (rsp_owner == RSP_DBG_ERR);

endmodule
